// File: rtl/parity_rx_checker.sv
// rtl/parity_rx_checker.sv - bit-serial start/data/parity/stop deframer with parity and framing checks
//
// Ports:
//    clk         system clock, rising edge
//    reset       synchronous active-high reset
//    sin         serial bit, sampled only when sin_valid=1
//    sin_valid   bit strobe, one frame bit consumed per strobed cycle
//    dout        received word (LSB received first), held between frames
//    dout_valid  one-cycle pulse when dout/par_err/frame_err are updated
//    par_err     parity mismatch on the last completed frame
//    frame_err   stop bit was 0 on the last completed frame
//    busy        high while a frame is in progress
//    err_cnt     saturating count of errored frames (only with PARITY_RX_ERR_CNT_EN)
//
// Optional feature macro: PARITY_RX_ERR_CNT_EN
module parity_rx_checker #(
   parameter int DATA_W     = 3,
   parameter int ODD_PARITY = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sin,
   input  logic              sin_valid,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              par_err,
   output logic              frame_err,
`ifdef PARITY_RX_ERR_CNT_EN
   output logic [7:0]        err_cnt,
`endif
   output logic              busy
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic ODD = (ODD_PARITY != 0);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DATA   = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;
   localparam logic [1:0] STOP   = 2'd3;

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] shift_q;
   logic              rp;
   logic              par_bad;

   // Received parity must equal XOR of data, inverted in odd mode.
   assign par_bad = rp ^ (^shift_q) ^ ODD;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         shift_q    <= '0;
         rp         <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         par_err    <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
`ifdef PARITY_RX_ERR_CNT_EN
         err_cnt    <= 8'd0;
`endif
      end else begin
         dout_valid <= 1'b0;
         if (sin_valid) begin
            case (state)
               IDLE: begin
                  // sin=1 is idle line; sin=0 is the start bit
                  if (!sin) begin
                     state <= DATA;
                     cnt   <= '0;
                     busy  <= 1'b1;
                  end
               end
               DATA: begin
                  // Decoded write so cnt never indexes past the word
                  for (int i = 0; i < DATA_W; i++) begin
                     if (cnt == CNT_W'(i)) shift_q[i] <= sin;
                  end
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST_BIT) state <= PARITY;
               end
               PARITY: begin
                  rp    <= sin;
                  state <= STOP;
               end
               STOP: begin
                  // A 0 stop bit is a framing error, not a new start bit
                  state      <= IDLE;
                  busy       <= 1'b0;
                  dout       <= shift_q;
                  dout_valid <= 1'b1;
                  par_err    <= par_bad;
                  frame_err  <= ~sin;
`ifdef PARITY_RX_ERR_CNT_EN
                  if ((par_bad || !sin) && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
`endif
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_parity_rx_checker.sv
// tb/tb_parity_rx_checker.sv - scoreboard bench for parity_rx_checker (even and odd instances)
module tb_parity_rx_checker;

   localparam int W = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sin_e = 1'b1, sin_valid_e = 1'b0;
   logic sin_o = 1'b1, sin_valid_o = 1'b0;
   logic [W-1:0] dout_e, dout_o;
   logic dout_valid_e, dout_valid_o, par_err_e, par_err_o, frame_err_e, frame_err_o, busy_e, busy_o;
`ifdef PARITY_RX_ERR_CNT_EN
   logic [7:0] err_cnt_e, err_cnt_o;
`endif

   int n_checks = 0;
   int n_fail = 0;
   int frames_e = 0, frames_o = 0;
   int valids_e = 0, valids_o = 0;
   int err_exp_e = 0, err_exp_o = 0;
   logic [W+1:0] q_e[$];
   logic [W+1:0] q_o[$];

   always #5 clk = ~clk;

   parity_rx_checker #(.DATA_W(W), .ODD_PARITY(0)) dut_e (
      .clk(clk), .reset(reset), .sin(sin_e), .sin_valid(sin_valid_e),
      .dout(dout_e), .dout_valid(dout_valid_e), .par_err(par_err_e), .frame_err(frame_err_e),
`ifdef PARITY_RX_ERR_CNT_EN
      .err_cnt(err_cnt_e),
`endif
      .busy(busy_e));

   parity_rx_checker #(.DATA_W(W), .ODD_PARITY(1)) dut_o (
      .clk(clk), .reset(reset), .sin(sin_o), .sin_valid(sin_valid_o),
      .dout(dout_o), .dout_valid(dout_valid_o), .par_err(par_err_o), .frame_err(frame_err_o),
`ifdef PARITY_RX_ERR_CNT_EN
      .err_cnt(err_cnt_o),
`endif
      .busy(busy_o));

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: pop one expected {dout, par_err, frame_err} per valid pulse
   always @(negedge clk) begin
      if (dout_valid_e === 1'b1) begin
         valids_e++;
         if (q_e.size() == 0) check("unexpected_valid_even", 16'd1, 16'd0);
         else check("frame_even", {11'd0, dout_e, par_err_e, frame_err_e}, {11'd0, q_e.pop_front()});
      end
      if (dout_valid_o === 1'b1) begin
         valids_o++;
         if (q_o.size() == 0) check("unexpected_valid_odd", 16'd1, 16'd0);
         else check("frame_odd", {11'd0, dout_o, par_err_o, frame_err_o}, {11'd0, q_o.pop_front()});
      end
   end

   task automatic beat(input bit sel, input logic b);
      @(negedge clk);
      if (sel) begin sin_o = b; sin_valid_o = 1'b1; end
      else begin sin_e = b; sin_valid_e = 1'b1; end
      @(posedge clk);
      #1;
      sin_valid_e = 1'b0; sin_valid_o = 1'b0; sin_e = 1'b1; sin_o = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives a whole frame; returns just after the stop beat edge (+1)
   task automatic send_frame(input bit sel, input logic [W-1:0] data, input logic p,
                             input logic stop, input int gap, input int pre);
      logic pe;
      logic fe;
      repeat (pre) beat(sel, 1'b1);
      beat(sel, 1'b0);
      idle(gap);
      for (int i = 0; i < W; i++) begin
         beat(sel, data[i]);
         idle(gap);
      end
      beat(sel, p);
      idle(gap);
      pe = (p != ((^data) ^ sel));
      fe = ~stop;
      if (sel) begin
         q_o.push_back({data, pe, fe}); frames_o++;
         if ((pe || fe) && err_exp_o < 255) err_exp_o++;
      end else begin
         q_e.push_back({data, pe, fe}); frames_e++;
         if ((pe || fe) && err_exp_e < 255) err_exp_e++;
      end
      beat(sel, stop);
   endtask

   task automatic check_cnt(input string tag);
`ifdef PARITY_RX_ERR_CNT_EN
      check({tag, "_err_cnt_even"}, {8'd0, err_cnt_e}, 16'(err_exp_e));
      check({tag, "_err_cnt_odd"}, {8'd0, err_cnt_o}, 16'(err_exp_o));
`else
      check({tag, "_no_cnt_even_busy"}, {15'd0, busy_e}, 16'd0);
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_dout", {13'd0, dout_e}, 16'd0);
      check("rst_valid", {15'd0, dout_valid_e}, 16'd0);
      check("rst_par_err", {15'd0, par_err_e}, 16'd0);
      check("rst_frame_err", {15'd0, frame_err_e}, 16'd0);
      check("rst_busy", {15'd0, busy_e}, 16'd0);
      check_cnt("rst");

      // 1: clean even frame, latency and single-cycle pulse
      beat(1'b0, 1'b0);
      check("busy_after_start", {15'd0, busy_e}, 16'd1);
      beat(1'b0, 1'b1); beat(1'b0, 1'b0); beat(1'b0, 1'b1);
      beat(1'b0, 1'b0);
      q_e.push_back({3'b101, 1'b0, 1'b0}); frames_e++;
      beat(1'b0, 1'b1);
      check("s1_valid_latency", {15'd0, dout_valid_e}, 16'd1);
      check("s1_busy_done", {15'd0, busy_e}, 16'd0);
      idle(1);
      check("s1_valid_one_cycle", {15'd0, dout_valid_e}, 16'd0);
      check("s1_dout_hold", {13'd0, dout_e}, 16'b101);
      check_cnt("s1");

      // 2: bad parity
      send_frame(1'b0, 3'b101, 1'b1, 1'b1, 0, 0);
      idle(1);
      check_cnt("s2");

      // 3: framing error then back-to-back good frame started on the valid cycle
      send_frame(1'b0, 3'b011, 1'b0, 1'b0, 0, 0);
      check("s3_busy_idle", {15'd0, busy_e}, 16'd0);
      send_frame(1'b0, 3'b110, 1'b0, 1'b1, 0, 0);
      idle(1);
      check("s3_errs_clear", {14'd0, par_err_e, frame_err_e}, 16'd0);
      check_cnt("s3");

      // 4: odd parity instance
      send_frame(1'b1, 3'b111, 1'b0, 1'b1, 0, 0);
      send_frame(1'b1, 3'b111, 1'b1, 1'b1, 0, 0);
      idle(1);
      check("s4_par_err_hold", {15'd0, par_err_o}, 16'd1);
      check_cnt("s4");

      // 5: gaps between every beat plus idle-line beats before start
      send_frame(1'b0, 3'b101, 1'b0, 1'b1, 5, 3);
      idle(1);
      check_cnt("s5");

      // 6: reset mid-frame aborts with no pulse
      beat(1'b0, 1'b0); beat(1'b0, 1'b1); beat(1'b0, 1'b0);
      check("s6_busy_mid", {15'd0, busy_e}, 16'd1);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      err_exp_e = 0; err_exp_o = 0;
      check("s6_busy_rst", {15'd0, busy_e}, 16'd0);
      check("s6_dout_rst", {13'd0, dout_e}, 16'd0);
      idle(3);
      send_frame(1'b0, 3'b100, 1'b1, 1'b1, 0, 0);
      idle(1);
      check("s6_dout", {13'd0, dout_e}, 16'b100);
      check_cnt("s6");
`ifdef PARITY_RX_ERR_CNT_EN
      for (int k = 0; k < 300; k++) send_frame(1'b0, W'(k), ~(^W'(k)), 1'b1, 0, 0);
      idle(1);
      check_cnt("s6_sat");
`endif

      idle(3);
      check("total_valid_even", 16'(valids_e), 16'(frames_e));
      check("total_valid_odd", 16'(valids_o), 16'(frames_o));
      check("queue_even_empty", 16'(q_e.size()), 16'd0);
      check("queue_odd_empty", 16'(q_o.size()), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
